// File: rtl/fifo_wr_arb_ctrl_if.sv
// Write-side bus of the async FIFO: two requesters, the shared memory
// write port, and the pointer/flag exchange with the read domain.
interface fifo_wr_arb_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W:0]   rq2_wptr;
  logic              gnt0;
  logic              gnt1;
  logic              winc;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W:0]   wptr;
  logic              wfull;
  logic              walmost_full;

  // Requesters plus read-pointer source side
  modport master (
    output req0, req1, wdata0, wdata1, rq2_wptr,
    input  gnt0, gnt1, winc, waddr, wdata, wptr, wfull, walmost_full
  );

  // Arbiter / write-pointer controller side
  modport slave (
    input  req0, req1, wdata0, wdata1, rq2_wptr,
    output gnt0, gnt1, winc, waddr, wdata, wptr, wfull, walmost_full
  );
endinterface

// File: rtl/fifo_wr_arb_ctrl.sv
// Two-requester round-robin write arbiter and write-pointer/full-flag
// logic for the write domain of an asynchronous FIFO.
module fifo_wr_arb_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int AF_LVL = 2
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arb_ctrl_if.slave bus
);

  localparam int              DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AF_THR = (ADDR_W + 1)'(DEPTH - AF_LVL);

  logic [ADDR_W:0]   wbin;
  logic [ADDR_W:0]   wbin_next;
  logic [ADDR_W:0]   wgray_next;
  logic [ADDR_W:0]   rbin;
  logic [ADDR_W:0]   fill_cnt;
  logic [ADDR_W:0]   full_cmp;
  logic [ADDR_W:0]   wptr_q;
  logic              wfull_q;
  logic              walmost_q;
  logic              last_gnt1;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              winc_c;
  logic              full_next;
  logic [DATA_W-1:0] wdata_c;

  // Grant: single requester wins outright, ties go to whoever was not served
  // last; nothing is granted while full or while reset is asserted.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst && !wfull_q) begin
      if (bus.req0 && bus.req1) begin
        if (last_gnt1) gnt0_c = 1'b1;
        else           gnt1_c = 1'b1;
      end else if (bus.req0) begin
        gnt0_c = 1'b1;
      end else if (bus.req1) begin
        gnt1_c = 1'b1;
      end
    end
    winc_c = gnt0_c | gnt1_c;
  end

  // Write data mux follows the grant; idle bus is driven to zero
  always_comb begin
    wdata_c = '0;
    if (gnt0_c)      wdata_c = bus.wdata0;
    else if (gnt1_c) wdata_c = bus.wdata1;
  end

  // Gray-to-binary of the synchronized read pointer: each bit is the XOR of
  // all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(bus.rq2_wptr >> i);
    end
  end

  // Next pointer, its Gray form, and the flag terms evaluated on it so a
  // write and a read-pointer move in the same cycle are both accounted for.
  always_comb begin
    wbin_next  = wbin + {{ADDR_W{1'b0}}, winc_c};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_cmp   = {~bus.rq2_wptr[ADDR_W:ADDR_W-1], bus.rq2_wptr[ADDR_W-2:0]};
    full_next  = (wgray_next == full_cmp);
    fill_cnt   = wbin_next - rbin;
  end

  // Pointer, flag and round-robin state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin      <= '0;
      wptr_q    <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      last_gnt1 <= 1'b1;
    end else begin
      wbin      <= wbin_next;
      wptr_q    <= wgray_next;
      wfull_q   <= full_next;
      // full always implies almost-full, even for AF_LVL settings where the
      // count threshold alone would not guarantee it
      walmost_q <= (fill_cnt >= AF_THR) || full_next;
      if (winc_c) last_gnt1 <= gnt1_c;
    end
  end

  assign bus.gnt0         = gnt0_c;
  assign bus.gnt1         = gnt1_c;
  assign bus.winc         = winc_c;
  assign bus.waddr        = wbin[ADDR_W-1:0];
  assign bus.wdata        = wdata_c;
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_q;

endmodule

// File: doc/fifo_wr_arb_ctrl.md
FIFO_WR_ARB_CTRL -- requirements
Module: fifo_wr_arb_ctrl

Interface
REQ-001 Parameter: DATA_W, 8, data width of each requester and of the write port.
REQ-002 Parameter: ADDR_W, 3, FIFO address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits.
REQ-003 Parameter: AF_LVL, 2, walmost_full asserts when free slots <= AF_LVL.
REQ-004 clk  in  1  write-domain clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  in  1  write request from requester 0 / 1.
REQ-007 wdata0 / wdata1  in  DATA_W  write data from requester 0 / 1.
REQ-008 rq2_wptr  in  ADDR_W+1  Gray read pointer, already two-flop synchronized into clk domain.
REQ-009 gnt0 / gnt1  out  1  combinational grant; the requester's word is written this cycle.
REQ-010 winc  out  1  memory write enable.
REQ-011 waddr  out  ADDR_W  memory write address.
REQ-012 wdata  out  DATA_W  memory write data (granted requester's data).
REQ-013 wptr  out  ADDR_W+1  registered Gray write pointer, to read-domain synchronizer.
REQ-014 wfull  out  1  registered FIFO-full flag.
REQ-015 walmost_full  out  1  registered almost-full flag.

Function
REQ-016 winc SHALL = (req0 | req1) & ~wfull; gnt0/gnt1 SHALL be one-hot or zero and SHALL be zero when wfull=1.
REQ-017 Single request: that requester is granted.
REQ-018 Both requesting: grant the requester not served by the most recent accepted write (round-robin); the last-served register updates only when winc=1.
REQ-019 wdata SHALL be wdata0 when gnt0, wdata1 when gnt1, all-zeros when no grant.
REQ-020 Internal binary pointer wbin (ADDR_W+1 bits) SHALL increment by 1 on each clk edge with winc=1, wrapping from 2**(ADDR_W+1)-1 to 0.
REQ-021 waddr SHALL equal wbin[ADDR_W-1:0] (write goes to current address; pointer advances at that edge).
REQ-022 wptr SHALL be registered Gray of next binary pointer: wptr <= wbin_next ^ (wbin_next >> 1); zero write latency between wbin and wptr.
REQ-023 wfull SHALL be registered: wfull <= (gray(wbin_next) == {~rq2_wptr[ADDR_W:ADDR_W-1], rq2_wptr[ADDR_W-2:0]}).
REQ-024 wfull SHALL deassert only after rq2_wptr advances; it is pessimistic by the synchronizer latency and SHALL never permit overflow.
REQ-025 Fill count SHALL be wbin_next - gray2bin(rq2_wptr), modulo 2**(ADDR_W+1); walmost_full <= (count >= DEPTH - AF_LVL).
REQ-026 walmost_full SHALL be asserted whenever wfull is asserted.
REQ-027 A request while wfull=1 is held off, not dropped; the requester holds req and data until granted.
REQ-028 rq2_wptr changing in the same cycle as winc=1 SHALL use both the new pointer and the increment in the same flag evaluation.

Reset
REQ-029 On rst=0, asynchronously: wbin=0, wptr=0, wfull=0, walmost_full=0, last-served=requester 1 (requester 0 wins first tie).
REQ-030 During reset, gnt0/gnt1/winc SHALL be 0 regardless of requests.
REQ-031 Reset mid-operation discards all pointer and flag state; no partial write occurs on the reset cycle.

Verification
REQ-032 Reset: assert rst=0 with req0=req1=1 -> gnt0=gnt1=winc=0, wptr=0, wfull=0, walmost_full=0.
REQ-033 Fill: rq2_wptr=0, req0=1 for 8 cycles -> waddr 0..7, wptr 1,3,2,6,7,5,4,C (hex); walmost_full high after 6th write; wfull high after 8th; 9th cycle gnt0=0.
REQ-034 Arbitration: req0=req1=1 continuously, not full -> grants alternate gnt0,gnt1,gnt0,gnt1; wdata tracks the granted source.
REQ-035 Release: from full (wptr=C), set rq2_wptr=1 -> wfull low next cycle; one write accepted at waddr 0; wfull re-asserts (wptr=D).
REQ-036 Wrap: stream 20 writes with rq2_wptr tracking wptr two cycles late -> wbin wraps 15->0, waddr wraps 7->0, no wfull false trigger, Gray sequence single-bit changes.
REQ-037 Mid-operation reset: after 5 writes, pulse rst=0 -> wptr=0, waddr=0, flags 0; next tie grants requester 0.
